full_adder_core: RTL and testbench

- Single-bit (parameterizable to WIDTH-bit ripple) binary full adder: sum and carry-out of a + b + Cin.
- Primary outputs s/Cout are purely combinational and follow the inputs with zero clock latency. This is the leaf arithmetic cell used by adder chains.
- Adds a registered copy of the result (s_q/cout_q) for pipelined users, clocked by clk and cleared by a synchronous reset.

---
 rtl/full_adder_core_if.sv | 33 +++
 rtl/full_adder_core.sv | 40 ++++
 tb/tb_full_adder_core.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/full_adder_core_if.sv
// Operand and result bundle for full_adder_core: addends and carry-in in,
// combinational and registered sum/carry out.
interface full_adder_core_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             Cin;
    logic [WIDTH-1:0] s;
    logic             Cout;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;

    modport master (
        output a,
        output b,
        output Cin,
        input  s,
        input  Cout,
        input  s_q,
        input  cout_q
    );

    modport slave (
        input  a,
        input  b,
        input  Cin,
        output s,
        output Cout,
        output s_q,
        output cout_q
    );
endinterface

// File: rtl/full_adder_core.sv
// WIDTH-bit ripple-carry full adder with zero-latency outputs and a
// one-cycle registered copy cleared by synchronous reset.
module full_adder_core #(
    parameter int unsigned WIDTH = 1
) (
    input logic             clk,
    input logic             rst,
    full_adder_core_if.slave bus
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    // Explicit bit-cell chain so the carry path stays a true ripple.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = bus.Cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum[i]     = bus.a[i] ^ bus.b[i] ^ carry[i];
            carry[i+1] = (bus.a[i] & bus.b[i]) | (carry[i] & (bus.a[i] ^ bus.b[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum;
            carry_q <= carry[WIDTH];
        end
    end

    assign bus.s      = sum;
    assign bus.Cout   = carry[WIDTH];
    assign bus.s_q    = sum_q;
    assign bus.cout_q = carry_q;
endmodule

// File: tb/tb_full_adder_core.sv
// Bench for full_adder_core: truth-table vectors at WIDTH=1, registered-path
// and reset sequences, and random WIDTH=4 vectors against an arithmetic model.
module tb_full_adder_core;
    logic clk;
    logic rst;
    logic clk_run;
    int   n_tests;
    int   n_fail;

    full_adder_core_if #(.WIDTH(1)) bus1 ();
    full_adder_core_if #(.WIDTH(4)) bus4 ();

    full_adder_core #(.WIDTH(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    full_adder_core #(.WIDTH(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    typedef struct {
        logic a;
        logic b;
        logic cin;
        logic s;
        logic co;
    } vec1_t;

    vec1_t tt[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rc;
        int         e;
        int         prev_e;
        bit         prev_valid;

        n_tests = 0;
        n_fail  = 0;
        clk_run = 1'b0;
        rst     = 1'b0;

        // Truth table from the cell definition, (a,b,Cin) -> (s,Cout).
        tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tt[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tt[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tt[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tt[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tt[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tt[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tt[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        bus4.a   = 4'h0;
        bus4.b   = 4'h0;
        bus4.Cin = 1'b0;

        // Clock idle: purely combinational behaviour.
        for (int i = 0; i < 8; i++) begin
            bus1.a   = tt[i].a;
            bus1.b   = tt[i].b;
            bus1.Cin = tt[i].cin;
            #4;
            check($sformatf("tt%0d_s", i), 64'(bus1.s), 64'(tt[i].s));
            check($sformatf("tt%0d_cout", i), 64'(bus1.Cout), 64'(tt[i].co));
            #1;
        end

        // Reset both DUTs with the clock running.
        clk_run = 1'b1;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        check("rst_s_q", 64'(bus1.s_q), 64'd0);
        check("rst_cout_q", 64'(bus1.cout_q), 64'd0);
        check("rst4_s_q", 64'(bus4.s_q), 64'd0);
        check("rst4_cout_q", 64'(bus4.cout_q), 64'd0);

        // 1+1+1 is visible immediately, registered only after the edge.
        @(negedge clk);
        rst      = 1'b0;
        bus1.a   = 1'b1;
        bus1.b   = 1'b1;
        bus1.Cin = 1'b1;
        #1;
        check("p111_s", 64'(bus1.s), 64'd1);
        check("p111_cout", 64'(bus1.Cout), 64'd1);
        check("p111_s_q_before", 64'(bus1.s_q), 64'd0);
        check("p111_cout_q_before", 64'(bus1.cout_q), 64'd0);
        @(posedge clk);
        #1;
        check("p111_s_q_after", 64'(bus1.s_q), 64'd1);
        check("p111_cout_q_after", 64'(bus1.cout_q), 64'd1);

        // Mid-stream reset clears registers but not the combinational outputs.
        @(negedge clk);
        rst      = 1'b1;
        bus1.Cin = 1'b0;
        #1;
        check("mrst_s", 64'(bus1.s), 64'd0);
        check("mrst_cout", 64'(bus1.Cout), 64'd1);
        @(posedge clk);
        #1;
        check("mrst_s_q", 64'(bus1.s_q), 64'd0);
        check("mrst_cout_q", 64'(bus1.cout_q), 64'd0);
        check("mrst_cout_held", 64'(bus1.Cout), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_s_q", 64'(bus1.s_q), 64'd0);
        check("post_rst_cout_q", 64'(bus1.cout_q), 64'd1);

        // WIDTH=4 directed carry ripple cases.
        @(negedge clk);
        bus4.a   = 4'b1111;
        bus4.b   = 4'b0000;
        bus4.Cin = 1'b1;
        #1;
        check("w4_ripple_s", 64'(bus4.s), 64'd0);
        check("w4_ripple_cout", 64'(bus4.Cout), 64'd1);
        @(negedge clk);
        bus4.a   = 4'b1010;
        bus4.b   = 4'b0101;
        bus4.Cin = 1'b0;
        #1;
        check("w4_alt_s", 64'(bus4.s), 64'hF);
        check("w4_alt_cout", 64'(bus4.Cout), 64'd0);
        @(negedge clk);
        bus4.a   = 4'b1111;
        bus4.b   = 4'b1111;
        bus4.Cin = 1'b1;
        #1;
        check("w4_allones_sum", 64'({bus4.Cout, bus4.s}), 64'd31);
        @(negedge clk);
        bus4.a   = 4'b0000;
        bus4.b   = 4'b0000;
        bus4.Cin = 1'b0;
        #1;
        check("w4_zero_sum", 64'({bus4.Cout, bus4.s}), 64'd0);

        // Random WIDTH=4 vectors; registers must trail by exactly one cycle.
        prev_valid = 1'b0;
        prev_e     = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            ra       = 4'($urandom_range(0, 15));
            rb       = 4'($urandom_range(0, 15));
            rc       = 1'($urandom_range(0, 1));
            bus4.a   = ra;
            bus4.b   = rb;
            bus4.Cin = rc;
            e        = int'(ra) + int'(rb) + int'(rc);
            #1;
            check($sformatf("rnd%0d_comb", i), 64'({bus4.Cout, bus4.s}), 64'(e));
            if (prev_valid) begin
                check($sformatf("rnd%0d_reg", i), 64'({bus4.cout_q, bus4.s_q}), 64'(prev_e));
            end
            prev_e     = e;
            prev_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        check("rnd_last_reg", 64'({bus4.cout_q, bus4.s_q}), 64'(prev_e));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
